// File: rtl/lab1_imul_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : lab1_imul_prod_accum
//  Purpose  : Product accumulator. Consumes the multiplier's response
//             stream over val/rdy and adds up groups of p_nprods products.
//             A flush closes a group early. Each group sum is presented with
//             its product count on an output val/rdy interface.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    p_nprods  products per group (legal range 1..63)
//  Ports
//    clk       clock; all state updates on the rising edge
//    reset     asynchronous, active-high
//    in_val    product valid                 in_rdy   block can take a product
//    in_msg    32-bit signed product         flush    close the current group
//    out_val   group sum valid               out_rdy  consumer takes the sum
//    out_msg   32-bit group sum              out_cnt  products in the group
//    out_sat   sum clamped during the group (constant 0 unless saturation)
//  Build option
//    LAB1_IMUL_PROD_ACCUM_SAT_EN  signed-saturating adds plus sticky out_sat.
//                                 When undefined, adds wrap modulo 2^32.
// ============================================================================
module lab1_imul_prod_accum #(
  parameter int p_nprods = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_msg,
  input  logic        flush,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_msg,
  output logic [5:0]  out_cnt,
  output logic        out_sat
);

  localparam logic [5:0] c_NPRODS = 6'(p_nprods);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [5:0]  cnt_q;
  logic [5:0]  cnt_d;
  logic        w_accept;
  logic        w_close;

`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
  logic        sat_q;
  logic        sat_d;
  logic [32:0] w_sum;
  logic        w_ovf;
`endif

  // In ACCUM the block is always ready, so an accept is just in_val.
  always_comb begin
    w_accept = (state_q == ST_ACCUM) && in_val;
    cnt_d    = cnt_q + 6'(w_accept);
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
    // Sign-extended 33-bit sum: bit 32 is the true sign, and a disagreement
    // with bit 31 means the 32-bit result overflowed.
    w_sum = {in_msg[31], in_msg} + {acc_q[31], acc_q};
    w_ovf = w_sum[32] ^ w_sum[31];
    acc_d = acc_q;
    sat_d = sat_q;
    if (w_accept) begin
      if (w_ovf) begin
        acc_d = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        sat_d = 1'b1;
      end else begin
        acc_d = w_sum[31:0];
      end
    end
`else
    acc_d = w_accept ? (acc_q + in_msg) : acc_q;
`endif
    // A flush with nothing in the group (and nothing accepted) is ignored.
    w_close = (w_accept && (cnt_d == c_NPRODS)) || (flush && (cnt_d != 6'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= 32'd0;
      cnt_q   <= 6'd0;
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
          sat_q <= sat_d;
`endif
          if (w_close) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Sum is held until the consumer takes it; no bypass into ACCUM.
          if (out_rdy) begin
            state_q <= ST_ACCUM;
            acc_q   <= 32'd0;
            cnt_q   <= 6'd0;
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
            sat_q   <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  // Outputs come from registers only. in_rdy is additionally masked by
  // reset so the block refuses products while reset is held.
  assign in_rdy  = (state_q == ST_ACCUM) && !reset;
  assign out_val = (state_q == ST_DONE);
  assign out_msg = acc_q;
  assign out_cnt = cnt_q;
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
  assign out_sat = sat_q;
`else
  assign out_sat = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({in_val, out_rdy, flush}));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lab1_imul_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab1_imul_prod_accum
//  Purpose  : Directed and randomised self-checking bench for the product
//             accumulator (p_nprods = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lab1_imul_prod_accum;

  localparam int c_NP = 4;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        flush;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic [5:0]  out_cnt;
  logic        out_sat;

  int checks   = 0;
  int failures = 0;

  lab1_imul_prod_accum #(.p_nprods(c_NP)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .flush   (flush),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_cnt (out_cnt),
    .out_sat (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_val = 1'b0; in_msg = 32'd0; flush = 1'b0; out_rdy = 1'b1;
    #1;
    checks++;
    if ({in_rdy, out_val, out_msg, out_cnt, out_sat} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b val=%b msg=%h cnt=%0d sat=%b, need all 0",
               in_rdy, out_val, out_msg, out_cnt, out_sat);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b val=%b, need rdy=1 val=0", in_rdy, out_val);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_rdy = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_val = 1'b1; in_msg = 32'(v);
      checks++;
      if (in_rdy !== 1'b1) begin
        failures++;
        $display("FAIL basic_rdy%0d: got in_rdy=%b, need 1", v, in_rdy);
      end
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_msg !== 32'd10 || out_cnt !== 6'd4 || in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: got val=%b msg=%0d cnt=%0d rdy=%b, need 1/10/4/0",
               out_val, out_msg, out_cnt, in_rdy);
    end
    step();
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      failures++;
      $display("FAIL basic_return: got rdy=%b val=%b, need 1/0", in_rdy, out_val);
    end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      in_val = 1'b1; in_msg = 32'(v);
      step();
    end
    in_val = 1'b1; in_msg = 32'd100;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_val !== 1'b1 || out_msg !== 32'd10 || out_cnt !== 6'd4 || in_rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got val=%b msg=%0d cnt=%0d rdy=%b, need 1/10/4/0",
                 i, out_val, out_msg, out_cnt, in_rdy);
      end
      if (i < 2) step();
    end
    out_rdy = 1'b1;
    step();
    flush = 1'b1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b val=%b, need 1/0", in_rdy, out_val);
    end
    step();
    in_val = 1'b0; flush = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_msg !== 32'd100 || out_cnt !== 6'd1) begin
      failures++;
      $display("FAIL bp_next: got val=%b msg=%0d cnt=%0d, need 1/100/1",
               out_val, out_msg, out_cnt);
    end
    step();
  endtask

  task automatic test_flush();
    out_rdy = 1'b1;
    in_val = 1'b0; flush = 1'b1;
    step();
    checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got val=%b rdy=%b, need 0/1", out_val, in_rdy);
    end
    flush = 1'b0; in_val = 1'b1; in_msg = 32'd5;
    step();
    in_msg = 32'd6; flush = 1'b1;
    step();
    in_val = 1'b0; flush = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_msg !== 32'd11 || out_cnt !== 6'd2 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL flush_sum: got val=%b msg=%0d cnt=%0d sat=%b, need 1/11/2/0",
               out_val, out_msg, out_cnt, out_sat);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_msg;
    logic        exp_sat;
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
    exp_msg = 32'h7FFF_FFFF; exp_sat = 1'b1;
`else
    exp_msg = 32'h8000_0000; exp_sat = 1'b0;
`endif
    out_rdy = 1'b1;
    in_val = 1'b1; in_msg = 32'h7FFF_FFFF;
    step();
    in_msg = 32'd1;
    step();
    in_val = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_msg !== exp_msg || out_sat !== exp_sat || out_cnt !== 6'd2) begin
      failures++;
      $display("FAIL ovf_sum: got val=%b msg=%h sat=%b cnt=%0d, need 1/%h/%b/2",
               out_val, out_msg, out_sat, out_cnt, exp_msg, exp_sat);
    end
    step();
    in_val = 1'b1; in_msg = 32'd2; flush = 1'b1;
    step();
    in_val = 1'b0; flush = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_msg !== 32'd2 || out_sat !== 1'b0 || out_cnt !== 6'd1) begin
      failures++;
      $display("FAIL ovf_next: got val=%b msg=%h sat=%b cnt=%0d, need 1/2/0/1",
               out_val, out_msg, out_sat, out_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b1;
    in_val = 1'b1; in_msg = 32'd7;
    step();
    in_msg = 32'd8;
    step();
    in_val = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b0 || out_val !== 1'b0 || out_msg !== 32'd0 || out_cnt !== 6'd0) begin
      failures++;
      $display("FAIL rst_mid: got rdy=%b val=%b msg=%0d cnt=%0d, need all 0",
               in_rdy, out_val, out_msg, out_cnt);
    end
    #1 reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_msg = 32'd1;
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_msg !== 32'd4 || out_cnt !== 6'd4) begin
      failures++;
      $display("FAIL rst_after: got val=%b msg=%0d cnt=%0d, need 1/4/4",
               out_val, out_msg, out_cnt);
    end
    step();
  endtask

  // Random products (as a multiplier would emit) with random flush and
  // out_rdy, checked against a cycle model of the accumulator's behaviour.
  task automatic test_back_to_back();
    logic        m_done = 1'b0;
    logic [31:0] m_acc  = 32'd0;
    int          m_cnt  = 0;
    int          exp_total = 0;
    int          obs_total = 0;
    int          a;
    int          b;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a = int'($urandom_range(0, 4095)) - 2048;
      b = int'($urandom_range(0, 4095)) - 2048;
      in_val  = ($urandom_range(0, 3) != 0);
      in_msg  = 32'(a * b);
      flush   = ($urandom_range(0, 5) == 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      checks++;
      if (in_rdy !== !m_done || out_val !== m_done) begin
        failures++;
        $display("FAIL b2b_ctl cyc%0d: got rdy=%b val=%b, need %b/%b",
                 cyc, in_rdy, out_val, !m_done, m_done);
      end
      if (m_done) begin
        checks++;
        if (out_msg !== m_acc || out_cnt !== 6'(m_cnt)) begin
          failures++;
          $display("FAIL b2b_sum cyc%0d: got msg=%h cnt=%0d, need %h/%0d",
                   cyc, out_msg, out_cnt, m_acc, m_cnt);
        end
        if (out_rdy) begin
          exp_total += m_cnt;
          obs_total += int'(out_cnt);
          m_done = 1'b0; m_acc = 32'd0; m_cnt = 0;
        end
      end else begin
        if (in_val) begin
          m_acc = m_acc + in_msg;
          m_cnt = m_cnt + 1;
        end
        if ((in_val && m_cnt == c_NP) || (flush && m_cnt >= 1)) m_done = 1'b1;
      end
      step();
    end
    in_val = 1'b0; flush = 1'b0; out_rdy = 1'b1;
    checks++;
    if (obs_total !== exp_total || exp_total == 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d products out, need %0d (nonzero)", obs_total, exp_total);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
